// File: rtl/coord_entry_pkg.sv
// -----------------------------------------------------------------------------
// coord_entry_pkg
// Shared types for the player coordinate-entry stage.
//   entry_state_t : FSM states (EDIT -> FIRE -> HOLD -> EDIT)
//   coord_t       : 4-bit cursor coordinate
//   inc_coord()   : wrapping cursor increment
// -----------------------------------------------------------------------------
package coord_entry_pkg;

    typedef enum logic [1:0] {EDIT, FIRE, HOLD} entry_state_t;

    typedef logic [3:0] coord_t;

    // Anything at or above the limit wraps to 0. This also recovers a
    // coordinate that somehow ended up out of range.
    function automatic coord_t inc_coord(input coord_t c, input coord_t max_c);
        return (c >= max_c) ? coord_t'(0) : c + coord_t'(1);
    endfunction

endpackage

// File: rtl/coord_entry_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw asynchronous push-button:
//   2-FF synchronizer -> counter debouncer -> registered rising-edge detector.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous active-low reset
//   btn_raw in  raw button input (asynchronous)
//   level   out debounced button level
//   rise    out one-cycle pulse per debounced 0->1 transition
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          level_d_reg;
    logic          rise_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            rise_reg    <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= btn_raw;
            sync2_reg   <= sync1_reg;
            level_d_reg <= level_reg;
            // Registered edge so the total press latency is DEBOUNCE_CNT + 3.
            rise_reg    <= level_reg & ~level_d_reg;
            if (sync2_reg == level_reg) begin
                // Any return to the settled level restarts the stability count.
                cnt_reg <= '0;
            end else if (cnt_reg == LAST) begin
                // This is the DEBOUNCE_CNT-th consecutive differing cycle.
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/coord_entry.sv
// -----------------------------------------------------------------------------
// coord_entry
// Player coordinate-entry stage. Four debounced buttons step a 4-bit X/Y
// cursor; confirm issues a one-cycle k_r pulse and freezes the cursor until
// game control pulses release_lock.
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous active-low reset
//   btn_x        in  raw increment-X button
//   btn_y        in  raw increment-Y button
//   btn_clr      in  raw clear-cursor button
//   btn_ok       in  raw confirm button
//   release_lock in  one-cycle pulse ending HOLD
//   x_out        out current/frozen X coordinate
//   y_out        out current/frozen Y coordinate
//   k_r          out one-cycle ready pulse (state FIRE)
//   locked       out high while in HOLD
// -----------------------------------------------------------------------------
module coord_entry
    import coord_entry_pkg::*;
#(
    parameter int     DEBOUNCE_CNT = 1_000_000,
    parameter coord_t MAX_COORD    = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_x,
    input  logic       btn_y,
    input  logic       btn_clr,
    input  logic       btn_ok,
    input  logic       release_lock,
    output logic [3:0] x_out,
    output logic [3:0] y_out,
    output logic       k_r,
    output logic       locked
);

    // Button index order: 0 = X, 1 = Y, 2 = clr, 3 = ok.
    logic [3:0] btn_raw_vec;
    logic [3:0] rise_vec;
    // Debounced levels are not needed by this stage; only edges drive the FSM.
    logic [3:0] levels_unused;

    assign btn_raw_vec = {btn_ok, btn_clr, btn_y, btn_x};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CNT(DEBOUNCE_CNT)
            ) u_btn (
                .clk    (clk),
                .reset  (reset),
                .btn_raw(btn_raw_vec[gi]),
                .level  (levels_unused[gi]),
                .rise   (rise_vec[gi])
            );
        end
    endgenerate

    entry_state_t state_reg, state_next;
    coord_t       x_reg, x_next;
    coord_t       y_reg, y_next;
    logic         k_r_reg;
    logic         locked_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= EDIT;
            x_reg      <= '0;
            y_reg      <= '0;
            k_r_reg    <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            k_r_reg    <= (state_next == FIRE);
            locked_reg <= (state_next == HOLD);
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        unique case (state_reg)
            EDIT: begin
                // Priority: clr > ok > increments (X and Y may both apply).
                if (rise_vec[2]) begin
                    x_next = '0;
                    y_next = '0;
                end else if (rise_vec[3]) begin
                    state_next = FIRE;
                end else begin
                    if (rise_vec[0]) x_next = inc_coord(x_reg, MAX_COORD);
                    if (rise_vec[1]) y_next = inc_coord(y_reg, MAX_COORD);
                end
            end
            FIRE: state_next = HOLD;
            HOLD: begin
                // Button edges are dropped here; debouncers keep tracking so a
                // button still held at release cannot produce a fresh edge.
                if (release_lock) state_next = EDIT;
            end
            default: state_next = EDIT;
        endcase
    end

    assign x_out  = x_reg;
    assign y_out  = y_reg;
    assign k_r    = k_r_reg;
    assign locked = locked_reg;

endmodule

// File: tb/tb_coord_entry.sv
// -----------------------------------------------------------------------------
// tb_coord_entry
// Scoreboard bench for coord_entry with DEBOUNCE_CNT = 4 (latency L = 7).
// Every press pushes its expected visible effect (cycle, cursor, k_r) to a
// queue; a negedge monitor pops an entry whenever the cursor changes or k_r
// is high and compares it.
// -----------------------------------------------------------------------------
module tb_coord_entry;

    localparam int DB = 4;
    localparam int L  = DB + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bx = 1'b0, by = 1'b0, bc = 1'b0, bo = 1'b0, rl = 1'b0;
    logic [3:0] x_out, y_out;
    logic       k_r, locked;

    always #5 clk = ~clk;

    coord_entry #(
        .DEBOUNCE_CNT(DB),
        .MAX_COORD   (4'd9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_x       (bx),
        .btn_y       (by),
        .btn_clr     (bc),
        .btn_ok      (bo),
        .release_lock(rl),
        .x_out       (x_out),
        .y_out       (y_out),
        .k_r         (k_r),
        .locked      (locked)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] x;
        logic [3:0] y;
        logic       k;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model of the cursor and lock.
    logic [3:0] mx = 4'd0, my = 4'd0;
    bit         mlocked = 1'b0;

    function automatic logic [3:0] inc_m(input logic [3:0] c);
        return (c >= 4'd9) ? 4'd0 : c + 4'd1;
    endfunction

    task automatic push_exp(input int c, input logic [3:0] x, input logic [3:0] y, input logic k);
        exp_t e;
        e.cyc = c;
        e.x   = x;
        e.y   = y;
        e.k   = k;
        sb_q.push_back(e);
    endtask

    // Monitor: any cursor change or k_r cycle is one transaction.
    bit         mon_en = 1'b0;
    logic [3:0] px = 4'd0, py = 4'd0;
    always @(negedge clk) begin
        if (mon_en && (k_r || x_out !== px || y_out !== py)) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_event", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("evt_cycle", cyc, mon_e.cyc);
                check_val("evt_x", x_out, mon_e.x);
                check_val("evt_y", y_out, mon_e.y);
                check_val("evt_k", k_r, mon_e.k);
                $display("txn cyc=%0d x=%0d y=%0d k_r=%0d locked=%0d", cyc, x_out, y_out, k_r, locked);
            end
        end
        px <= x_out;
        py <= y_out;
    end

    // Clean press: drive on a negedge (edge 0 is the next posedge), hold long
    // enough to debounce, then release fully before returning.
    task automatic press(input bit ix, input bit iy, input bit iclr, input bit iok);
        logic [3:0] nx, ny;
        @(negedge clk);
        if (!mlocked) begin
            if (iclr) begin
                if (mx != 4'd0 || my != 4'd0) push_exp(cyc + L + 1, 4'd0, 4'd0, 1'b0);
                mx = 4'd0;
                my = 4'd0;
            end else if (iok) begin
                push_exp(cyc + L + 1, mx, my, 1'b1);
                mlocked = 1'b1;
            end else begin
                nx = ix ? inc_m(mx) : mx;
                ny = iy ? inc_m(my) : my;
                if (nx != mx || ny != my) push_exp(cyc + L + 1, nx, ny, 1'b0);
                mx = nx;
                my = ny;
            end
        end
        bx = ix; by = iy; bc = iclr; bo = iok;
        repeat (9) @(negedge clk);
        bx = 1'b0; by = 1'b0; bc = 1'b0; bo = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_release();
        @(negedge clk);
        rl = 1'b1;
        @(negedge clk);
        rl = 1'b0;
        mlocked = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_x", x_out, 0);
        check_val("rst_y", y_out, 0);
        check_val("rst_k", k_r, 0);
        check_val("rst_locked", locked, 0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check_val("idle_x", x_out, 0);
        check_val("idle_y", y_out, 0);
        check_val("idle_k", k_r, 0);
        check_val("idle_locked", locked, 0);
        mon_en = 1'b1;

        // 2. Wrap
        repeat (10) press(1, 0, 0, 0);
        check_val("wrap_x", x_out, 0);
        repeat (3) press(1, 0, 0, 0);
        check_val("post_wrap_x", x_out, 3);
        check_val("post_wrap_y", y_out, 0);

        // 3. Bounce: only the stable-high run produces one increment
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bx = 1'b1;
            repeat (2) @(negedge clk);
            bx = 1'b0;
            repeat (2) @(negedge clk);
        end
        push_exp(cyc + L + 1, inc_m(mx), my, 1'b0);
        mx = inc_m(mx);
        bx = 1'b1;
        repeat (10) @(negedge clk);
        bx = 1'b0;
        repeat (10) @(negedge clk);
        check_val("bounce_x", x_out, 4);

        // 4. Confirm / hold / release
        press(0, 0, 1, 0);
        repeat (3) press(1, 0, 0, 0);
        repeat (5) press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        check_val("hold_locked", locked, 1);
        repeat (2) press(1, 0, 0, 0);
        check_val("hold_x", x_out, 3);
        check_val("hold_y", y_out, 5);
        pulse_release();
        check_val("release_locked", locked, 0);
        press(1, 0, 0, 0);
        check_val("after_release_x", x_out, 4);

        // 5. clr and ok in the same cycle
        press(0, 0, 1, 0);
        repeat (7) press(1, 0, 0, 0);
        repeat (2) press(0, 1, 0, 0);
        check_val("pre_clrok_x", x_out, 7);
        check_val("pre_clrok_y", y_out, 2);
        press(0, 0, 1, 1);
        check_val("clrok_x", x_out, 0);
        check_val("clrok_y", y_out, 0);
        check_val("clrok_locked", locked, 0);

        // 6. ok held through HOLD and release
        repeat (3) press(1, 0, 0, 0);
        @(negedge clk);
        push_exp(cyc + L + 1, mx, my, 1'b1);
        mlocked = 1'b1;
        bo = 1'b1;
        repeat (14) @(negedge clk);
        check_val("held_ok_locked", locked, 1);
        pulse_release();
        check_val("held_ok_release", locked, 0);
        repeat (10) @(negedge clk);
        bo = 1'b0;
        repeat (10) @(negedge clk);
        check_val("held_ok_no_refire", locked, 0);
        press(0, 0, 0, 1);
        check_val("repress_locked", locked, 1);
        check_val("repress_x", x_out, 3);

        // 1b. Asynchronous reset in HOLD, between clock edges
        @(negedge clk);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("async_rst_x", x_out, 0);
        check_val("async_rst_y", y_out, 0);
        check_val("async_rst_k", k_r, 0);
        check_val("async_rst_locked", locked, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        check_val("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
